// File: rtl/fifo_lifo_queue.sv
// Single-clock storage queue serving FIFO or LIFO pops from one circular buffer.
// Mode is sampled per cycle. Contents never move, so a mode switch only changes which end is popped.
module fifo_lifo_queue #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             chip_en_i,
  input  logic             mode_i,
  input  logic             flush_i,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             valid_out_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, tail_m1, mem_waddr;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic             mem_we, rd_ok, wr_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign tail_m1 = (tail_q == '0) ? PW'(DEPTH - 1) : tail_q - PW'(1);
  assign rd_ok   = read_i && (count_q != '0);
  // A full queue still takes a write when a pop frees a slot in the same cycle.
  assign wr_ok   = write_i && ((count_q != CW'(DEPTH)) || rd_ok);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = tail_q;
    if (chip_en_i) begin
      if (flush_i) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        udf_d = read_i && !rd_ok;
        ovf_d = write_i && !wr_ok;
        if (rd_ok) begin
          valid_d    = 1'b1;
          data_out_d = mode_i ? mem_q[tail_m1] : mem_q[head_q];
        end
        if (rd_ok && wr_ok) begin
          mem_we = 1'b1;
          if (mode_i) begin
            // LIFO swap: the popped top slot is refilled in place.
            mem_waddr = tail_m1;
          end else begin
            head_d = ptr_inc(head_q);
            tail_d = ptr_inc(tail_q);
          end
        end else if (rd_ok) begin
          count_d = count_q - CW'(1);
          if (mode_i) tail_d = tail_m1;
          else        head_d = ptr_inc(head_q);
        end else if (wr_ok) begin
          mem_we  = 1'b1;
          tail_d  = ptr_inc(tail_q);
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) mem_q[mem_waddr] <= data_in_i;
  end

  assign data_out_o     = data_out_q;
  assign valid_out_o    = valid_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign count_o        = count_q;
  assign full_o         = (count_q == CW'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (32'(count_q) >= AF_LEVEL);
  assign almost_empty_o = (32'(count_q) <= AE_LEVEL);

endmodule

// File: tb/tb_fifo_lifo_queue.sv
// Directed bench for fifo_lifo_queue: expected pops go into a scoreboard queue,
// and a negedge monitor compares them against every valid_out pulse.
module tb_fifo_lifo_queue;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, chip_en, mode, flush, write, read;
  logic [WIDTH-1:0] data_in, data_out;
  logic             valid_out, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]    count;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  fifo_lifo_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .chip_en_i      (chip_en),
    .mode_i         (mode),
    .flush_i        (flush),
    .write_i        (write),
    .read_i         (read),
    .data_in_i      (data_in),
    .data_out_o     (data_out),
    .valid_out_o    (valid_out),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty),
    .count_o        (count),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid_out pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got 0x%0h expected no valid_out", data_out);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_err++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", data_out, e);
        end
      end
    end
  end

  task automatic op(input logic r, input logic w, input logic m, input logic [WIDTH-1:0] d,
                    input logic f, input logic ce);
    read = r; write = w; mode = m; data_in = d; flush = f; chip_en = ce;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; flush = 1'b0; chip_en = 1'b1;
  endtask

  task automatic push(input logic m, input logic [WIDTH-1:0] d);
    op(1'b0, 1'b1, m, d, 1'b0, 1'b1);
  endtask

  task automatic pop(input logic m, input logic [WIDTH-1:0] e);
    exp_q.push_back(e);
    op(1'b1, 1'b0, m, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; chip_en = 1'b1; mode = 1'b0; flush = 1'b0;
    write = 1'b0; read = 1'b0; data_in = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_pulses", {30'd0, overflow, underflow}, 0);

    // FIFO fill / overflow / drain / underflow
    for (int i = 9; i <= 16; i++) begin
      push(1'b0, 8'(i));
      if (i == 14) chk("af_at6", 32'(almost_full), 0);
      if (i == 15) chk("af_at7", 32'(almost_full), 1);
      if (i == 9)  chk("ae_at1", 32'(almost_empty), 1);
      if (i == 10) chk("ae_at2", 32'(almost_empty), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    push(1'b0, 8'd17);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    idle();
    chk("ovf_clear", 32'(overflow), 0);
    for (int i = 9; i <= 16; i++) pop(1'b0, 8'(i));
    chk("drain_empty", 32'(empty), 1);
    op(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_pulse", 32'(underflow), 1);
    chk("udf_valid", 32'(valid_out), 0);
    chk("udf_dout_held", 32'(data_out), 16);
    idle();
    chk("udf_clear", 32'(underflow), 0);

    // Move pointers to 5, then LIFO run that wraps tail
    for (int i = 0; i < 5; i++) push(1'b0, 8'(8'hE0 + i));
    for (int i = 0; i < 5; i++) pop(1'b0, 8'(8'hE0 + i));
    for (int i = 8; i <= 14; i++) push(1'b1, 8'(i));
    chk("lifo_count", 32'(count), 7);
    for (int i = 14; i >= 8; i--) pop(1'b1, 8'(i));
    chk("lifo_empty", 32'(empty), 1);

    // Mode switch preserves contents
    push(1'b0, 8'd8);
    push(1'b0, 8'd9);
    pop(1'b1, 8'd9);
    push(1'b1, 8'd10);
    push(1'b1, 8'd11);
    pop(1'b0, 8'd8);
    pop(1'b0, 8'd10);
    pop(1'b0, 8'd11);
    chk("mode_count", 32'(count), 0);

    // Full FIFO read+write
    for (int i = 1; i <= 8; i++) push(1'b0, 8'(i));
    exp_q.push_back(8'd1);
    op(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b1);
    chk("rw_full_count", 32'(count), 8);
    chk("rw_full_ovf", 32'(overflow), 0);
    for (int i = 2; i <= 8; i++) pop(1'b0, 8'(i));
    pop(1'b0, 8'hAA);

    // LIFO read+write swaps top
    push(1'b1, 8'h33);
    exp_q.push_back(8'h33);
    op(1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
    chk("rw_lifo_count", 32'(count), 1);
    pop(1'b1, 8'h44);

    // Read+write on empty: write alone, underflow
    op(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
    chk("rw_empty_udf", 32'(underflow), 1);
    chk("rw_empty_count", 32'(count), 1);
    chk("rw_empty_valid", 32'(valid_out), 0);
    pop(1'b0, 8'h55);

    // Flush with read+write
    push(1'b0, 8'h61);
    push(1'b0, 8'h62);
    op(1'b1, 1'b1, 1'b0, 8'h63, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_pulses", {30'd0, overflow, underflow}, 0);
    chk("flush_valid", 32'(valid_out), 0);
    chk("flush_dout", 32'(data_out), 8'h55);

    // chip_en=0 ignores write
    op(1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    chk("ce0_count", 32'(count), 0);
    op(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ce0_nothing_stored", 32'(underflow), 1);

    // Reset mid-operation with a read asserted
    for (int i = 0; i < 5; i++) push(1'b0, 8'(8'h80 + i));
    chk("pre_rst_count", 32'(count), 5);
    reset = 1'b1; read = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; read = 1'b0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_dout", 32'(data_out), 0);
    chk("mid_rst_valid", 32'(valid_out), 0);
    push(1'b0, 8'h90);
    pop(1'b0, 8'h90);
    idle();
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fifo_lifo_queue.md
# fifo_lifo_queue

- Parametrised single-clock storage queue that serves both FIFO and LIFO access from one circular buffer.
- Next generation of the team's FIFO/LIFO top:
  - generic width and depth;
  - per-cycle mode selection with contents preserved across mode switches;
  - synchronous flush;
  - occupancy count and programmable almost-full/almost-empty flags;
  - overflow/underflow pulses;
  - defined simultaneous read/write behaviour.
- Sits between a data producer and consumer wherever the design needs buffered or stack ordering.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of storage entries (≥2, need not be a power of two)
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL
- CW (localparam), $clog2(DEPTH+1), count width
- clk  input  1  single clock; everything on rising edge
- reset  input  1  synchronous, active-high
- chip_en  input  1  1 = block active; 0 = read/write/flush ignored, state held
- mode  input  1  0 = FIFO (pop oldest), 1 = LIFO (pop newest); sampled every cycle
- flush  input  1  synchronous clear of contents
- write  input  1  push request
- read  input  1  pop request
- dataIn  input  WIDTH  push data
- dataOut  output  WIDTH  registered pop data
- valid_out  output  1  one-cycle pulse: dataOut updated this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  CW  current occupancy
- overflow  output  1  one-cycle pulse: write rejected
- underflow  output  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH×WIDTH register array with pointers:
  - head = oldest entry;
  - tail = next free slot;
  - both wrap from DEPTH-1 to 0.
- Push always writes at tail, then tail+1.
- FIFO pop reads head, then head+1.
- LIFO pop reads tail-1 (wrapped), then tail-1.
- Switching mode never moves data. The next pop simply takes from the other end. Example: FIFO-push 8,9, then LIFO pop → 9.
- Cycle priority: reset > chip_en=0 > flush > read/write.
- flush (chip_en=1):
  - head = tail = 0, count = 0;
  - read/write in the same cycle are ignored, with no over/underflow pulse;
  - dataOut is held and valid_out = 0.
- Read accepted iff count > 0. Read on empty: no state change, underflow pulse. This holds even if write is asserted the same cycle; there is no write-through bypass, and the write alone is performed.
- Write accepted iff count < DEPTH, or a read is accepted the same cycle. Otherwise overflow pulse and data dropped.
- Simultaneous read+write with count > 0, FIFO mode:
  - pop head, push at tail;
  - count unchanged; legal when full.
- Simultaneous read+write with count > 0, LIFO mode:
  - dataOut = entry at tail-1;
  - dataIn overwrites that same slot;
  - tail and count unchanged; legal when full.
- count: +1 on write-only accept, −1 on read-only accept, unchanged otherwise. It never exceeds DEPTH or drops below 0.
- Flags are combinational from count (registered state). No extra latency beyond count.

## Timing
- Reset (clk edge with reset=1):
  - dataOut = 0, valid_out = 0, count = 0, head = tail = 0;
  - empty = 1, full = 0, almost_empty = 1;
  - almost_full = (AF_LEVEL == 0);
  - overflow = underflow = 0;
  - array contents don't-care.
- Reset mid-operation discards all contents in that edge. Any read in the same cycle produces no valid_out.
- Pop latency 1: a read accepted at edge N gives dataOut/valid_out valid after edge N, held until the next accepted pop.
- Push visible to a pop on the following cycle; count/flags update after the push edge.
- overflow/underflow assert for exactly the cycle after the offending edge.
- chip_en=0:
  - no pointer, count or dataOut change;
  - valid_out, overflow and underflow are 0.

## Test plan
- FIFO fill/drain, DEPTH=8:
  - push 9..16 → full=1, count=8, almost_full=1 from count 7;
  - push 17 → overflow pulse, count 8;
  - 8 reads → dataOut 9,10,…,16, each 1 cycle after its read;
  - ninth read → underflow, empty=1.
- LIFO: push 8..14 → 7 reads give 14,13,…,8. Wrap check: start from head=5 after a prior FIFO pass; pointer wrap yields identical ordering.
- Mode switch:
  - FIFO push 8,9;
  - switch mode=1, read → 9;
  - push 10,11;
  - switch mode=0, reads → 8,10,11; count ends 0.
- Simultaneous:
  - full FIFO read+write of 0xAA → count stays 8, oldest returned, 0xAA last out;
  - LIFO top=0x33, read+write 0x44 → dataOut 0x33, next pop 0x44;
  - empty read+write → underflow, count 1.
- Flush/reset/chip_en:
  - flush with read+write asserted → count 0, no pulses, dataOut held;
  - chip_en=0 with write → nothing stored;
  - reset asserted while count=5 → all outputs at reset values next cycle.
